// File: rtl/ecc_pkg.sv
// Shared types and defaults for the ECC accelerator arithmetic units.
// Holds the modular-op encoding, the add/sub unit states and the field-size defaults.
package ecc_pkg;

  localparam int ECC_WIDTH = 256;
  localparam int ECC_LIMB  = 64;

  typedef enum logic {
    MOD_ADD = 1'b0,
    MOD_SUB = 1'b1
  } modop_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } modaddsub_state_e;

  // Limb counter width; a single-limb datapath still needs a 1-bit counter.
  function automatic int cnt_width(input int nlimb);
    return (nlimb > 1) ? $clog2(nlimb) : 1;
  endfunction

endpackage

// File: rtl/limb_addsub_cell.sv
// One LIMB-bit add or subtract slice with carry/borrow in and out.
// cout is the carry-out in add mode and the borrow-out in subtract mode.
module limb_addsub_cell #(
  parameter int LIMB = 64
) (
  input  logic [LIMB-1:0] x,
  input  logic [LIMB-1:0] y,
  input  logic            cin,
  input  logic            sub,
  output logic [LIMB-1:0] sum,
  output logic            cout
);

  logic [LIMB:0] wide;

  // The extra top bit reads as 1 exactly when the subtraction went negative.
  always_comb begin
    wide = '0;
    if (sub) begin
      wide = {1'b0, x} - {1'b0, y} - {{LIMB{1'b0}}, cin};
    end else begin
      wide = {1'b0, x} + {1'b0, y} + {{LIMB{1'b0}}, cin};
    end
  end

  assign sum  = wide[LIMB-1:0];
  assign cout = wide[LIMB];

endmodule

// File: rtl/mod_addsub_unit.sv
// Multi-cycle modular adder/subtractor, one LIMB slice per cycle, LS limb first.
// Subtract mode is present only when MOD_ADDSUB_SUB_EN is defined; otherwise op_i is ignored.
//
// state | meaning
// IDLE  | waiting for start_i
// RUN   | processing limb cnt_q of the s and t chains
// DONE  | result_o just updated, valid_o high; start_i here begins the next op
module mod_addsub_unit
  import ecc_pkg::*;
#(
  parameter int WIDTH = ECC_WIDTH,
  parameter int LIMB  = ECC_LIMB
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] p_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int NLIMB = WIDTH / LIMB;
  localparam int CW    = cnt_width(NLIMB);
  localparam logic [CW-1:0] LAST = CW'(NLIMB - 1);

  modaddsub_state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, p_q, s_q, t_q, result_q;
  logic [WIDTH-1:0] s_next, t_next;
  logic [CW-1:0]    cnt_q;
  logic             c_s_q, c_t_q;
  logic             accept, last_limb, sub_mode, sel_t;
  logic [LIMB-1:0]  a_k, b_k, p_k, s_k, t_k;
  logic             s_cout, t_cout;
  int               base;

`ifdef MOD_ADDSUB_SUB_EN
  modop_e op_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q <= MOD_ADD;
    end else if (accept) begin
      op_q <= modop_e'(op_i);
    end
  end

  assign sub_mode = (op_q == MOD_SUB);
`else
  logic unused_op;
  assign unused_op = op_i;
  assign sub_mode  = 1'b0;
`endif

  assign accept    = start_i && (state_q != RUN);
  assign last_limb = (state_q == RUN) && (cnt_q == LAST);
  assign base      = int'(cnt_q) * LIMB;

  assign a_k = a_q[base +: LIMB];
  assign b_k = b_q[base +: LIMB];
  assign p_k = p_q[base +: LIMB];

  limb_addsub_cell #(.LIMB(LIMB)) u_s_cell (
    .x    (a_k),
    .y    (b_k),
    .cin  (c_s_q),
    .sub  (sub_mode),
    .sum  (s_k),
    .cout (s_cout)
  );

  // The t chain undoes or applies one modulus on the s chain's current limb.
  limb_addsub_cell #(.LIMB(LIMB)) u_t_cell (
    .x    (s_k),
    .y    (p_k),
    .cin  (c_t_q),
    .sub  (~sub_mode),
    .sum  (t_k),
    .cout (t_cout)
  );

  always_comb begin
    s_next = s_q;
    t_next = t_q;
    s_next[base +: LIMB] = s_k;
    t_next[base +: LIMB] = t_k;
  end

  assign sel_t = sub_mode ? s_cout : (s_cout | ~t_cout);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN:     if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = start_i ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q      <= '0;
      b_q      <= '0;
      p_q      <= '0;
      s_q      <= '0;
      t_q      <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      c_s_q    <= 1'b0;
      c_t_q    <= 1'b0;
    end else if (accept) begin
      a_q   <= a_i;
      b_q   <= b_i;
      p_q   <= p_i;
      cnt_q <= '0;
      c_s_q <= 1'b0;
      c_t_q <= 1'b0;
    end else if (state_q == RUN) begin
      s_q   <= s_next;
      t_q   <= t_next;
      c_s_q <= s_cout;
      c_t_q <= t_cout;
      cnt_q <= cnt_q + CW'(1);
      if (last_limb) begin
        result_q <= sel_t ? t_next : s_next;
      end
    end
  end

  assign busy_o   = (state_q == RUN);
  assign valid_o  = (state_q == DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_mod_addsub_unit.sv
// Self-checking bench for mod_addsub_unit (WIDTH=256, LIMB=64), randomized against a modular reference.
// Expected subtract results follow MOD_ADDSUB_SUB_EN: without it every op is an add.
module tb_mod_addsub_unit;
  import ecc_pkg::*;

  localparam int W = 256;
  localparam int L = 64;
  localparam int NL = W / L;
`ifdef MOD_ADDSUB_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         op;
  logic [W-1:0] a, b, p;
  logic         busy, valid;
  logic [W-1:0] result;

  int errors = 0;
  int checks = 0;

  mod_addsub_unit #(.WIDTH(W), .LIMB(L)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .start_i  (start),
    .op_i     (op),
    .a_i      (a),
    .b_i      (b),
    .p_i      (p),
    .busy_o   (busy),
    .valid_o  (valid),
    .result_o (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain modular arithmetic with a single correction step.
  function automatic logic [W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic [W-1:0] m, input logic o);
    logic [W:0] wide;
    if (o && SUB_EN) begin
      if (x < y) wide = {1'b0, x} + {1'b0, m} - {1'b0, y};
      else       wide = {1'b0, x} - {1'b0, y};
    end else begin
      wide = {1'b0, x} + {1'b0, y};
      if (wide >= {1'b0, m}) wide = wide - {1'b0, m};
    end
    return wide[W-1:0];
  endfunction

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Issue one op and watch cycles 1..10 after acceptance.
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] m,
                       input logic o, output logic [W-1:0] res, output int vcyc,
                       output int bfirst, output int nbusy, output int nvalid);
    a = x; b = y; p = m; op = o; start = 1'b1;
    tick();
    start = 1'b0;
    res = 'x; vcyc = -1; bfirst = -1; nbusy = 0; nvalid = 0;
    for (int c = 1; c <= 10; c++) begin
      if (busy) begin
        nbusy++;
        if (bfirst < 0) bfirst = c;
      end
      if (valid) begin
        nvalid++;
        if (vcyc < 0) begin
          vcyc = c;
          res  = result;
        end
      end
      if (c < 10) tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0; p = '0;
    tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (result !== '0) begin errors++; $display("FAIL reset_result got=%h exp=0", result); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add_basic();
    logic [W-1:0] r, exp_r;
    int vc, bf, nb, nv;
    do_op(W'(50), W'(40), W'(97), 1'b0, r, vc, bf, nb, nv);
    exp_r = W'(90);
    checks++; if (r !== exp_r) begin errors++; $display("FAIL add_50_40 got=%0d exp=%0d", r, exp_r); end
    checks++; if (vc !== NL + 1) begin errors++; $display("FAIL add_latency got=%0d exp=%0d", vc, NL + 1); end
    checks++; if (bf !== 1) begin errors++; $display("FAIL busy_first got=%0d exp=1", bf); end
    checks++; if (nb !== NL) begin errors++; $display("FAIL busy_cycles got=%0d exp=%0d", nb, NL); end
    checks++; if (nv !== 1) begin errors++; $display("FAIL valid_pulses got=%0d exp=1", nv); end
    checks++; if (result !== exp_r) begin errors++; $display("FAIL result_hold got=%0d exp=%0d", result, exp_r); end
    do_op(W'(60), W'(50), W'(97), 1'b0, r, vc, bf, nb, nv);
    exp_r = W'(13);
    checks++; if (r !== exp_r) begin errors++; $display("FAIL add_60_50 got=%0d exp=%0d", r, exp_r); end
    do_op(W'(96), W'(1), W'(97), 1'b0, r, vc, bf, nb, nv);
    exp_r = W'(0);
    checks++; if (r !== exp_r) begin errors++; $display("FAIL add_96_1 got=%0d exp=%0d", r, exp_r); end
  endtask

  task automatic test_p256();
    logic [W-1:0] p256, r, exp_r;
    int vc, bf, nb, nv;
    p256 = {64'hFFFFFFFF00000001, 64'h0000000000000000, 64'h00000000FFFFFFFF, 64'hFFFFFFFFFFFFFFFF};
    exp_r = p256 - W'(2);
    do_op(p256 - W'(1), p256 - W'(1), p256, 1'b0, r, vc, bf, nb, nv);
    checks++; if (r !== exp_r) begin errors++; $display("FAIL p256_add got=%h exp=%h", r, exp_r); end
    checks++; if (vc !== NL + 1) begin errors++; $display("FAIL p256_latency got=%0d exp=%0d", vc, NL + 1); end
  endtask

  task automatic test_sub();
    logic [W-1:0] r, exp_r;
    int vc, bf, nb, nv;
    do_op(W'(10), W'(20), W'(97), 1'b1, r, vc, bf, nb, nv);
    exp_r = SUB_EN ? W'(87) : W'(30);
    checks++; if (r !== exp_r) begin errors++; $display("FAIL sub_10_20 got=%0d exp=%0d", r, exp_r); end
    do_op(W'(20), W'(10), W'(97), 1'b1, r, vc, bf, nb, nv);
    exp_r = SUB_EN ? W'(10) : W'(30);
    checks++; if (r !== exp_r) begin errors++; $display("FAIL sub_20_10 got=%0d exp=%0d", r, exp_r); end
    do_op(W'(5), W'(5), W'(97), 1'b1, r, vc, bf, nb, nv);
    exp_r = SUB_EN ? W'(0) : W'(10);
    checks++; if (r !== exp_r) begin errors++; $display("FAIL sub_5_5 got=%0d exp=%0d", r, exp_r); end
  endtask

  task automatic test_random();
    logic [W-1:0] m, x, y, r, exp_r;
    logic o;
    int vc, bf, nb, nv;
    for (int i = 0; i < 24; i++) begin
      m = rand_w();
      if (i % 3 == 1) m = m >> $urandom_range(W - 8, 1);
      m[0] = 1'b1;
      x = rand_w() % m;
      y = rand_w() % m;
      if (i % 4 == 2) y = x;
      o = 1'($urandom_range(1, 0));
      exp_r = model(x, y, m, o);
      do_op(x, y, m, o, r, vc, bf, nb, nv);
      checks++;
      if (r !== exp_r || vc !== NL + 1 || nv !== 1) begin
        errors++;
        $display("FAIL rand_%0d op=%0d got=%h exp=%h vcyc=%0d pulses=%0d", i, o, r, exp_r, vc, nv);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] xs[3], ys[3], ms[3], exps[3];
    logic         os[3];
    int vcyc[3];
    int nv, nxt, cyc;
    bit load_pending;
    for (int i = 0; i < 3; i++) begin
      ms[i] = rand_w(); ms[i][0] = 1'b1;
      xs[i] = rand_w() % ms[i];
      ys[i] = rand_w() % ms[i];
      os[i] = 1'(i == 1);
      exps[i] = model(xs[i], ys[i], ms[i], os[i]);
    end
    a = xs[0]; b = ys[0]; p = ms[0]; op = os[0]; start = 1'b1;
    tick();
    nv = 0; nxt = 1; load_pending = 1'b1; cyc = 1;
    while (nv < 3 && cyc <= 30) begin
      if (load_pending && nxt < 3) begin
        a = xs[nxt]; b = ys[nxt]; p = ms[nxt]; op = os[nxt];
        nxt++;
        load_pending = 1'b0;
      end
      if (valid) begin
        vcyc[nv] = cyc;
        checks++;
        if (result !== exps[nv]) begin
          errors++;
          $display("FAIL b2b_result_%0d got=%h exp=%h", nv, result, exps[nv]);
        end
        nv++;
        load_pending = 1'b1;
        if (nv == 3) start = 1'b0;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    checks++; if (nv !== 3) begin errors++; $display("FAIL b2b_count got=%0d exp=3", nv); end
    if (nv == 3) begin
      checks++;
      if (vcyc[0] !== 5 || vcyc[1] !== 10 || vcyc[2] !== 15) begin
        errors++;
        $display("FAIL b2b_spacing got=%0d,%0d,%0d exp=5,10,15", vcyc[0], vcyc[1], vcyc[2]);
      end
    end
    tick(); tick();
  endtask

  task automatic test_start_in_run();
    logic [W-1:0] exp_r;
    int vc, nv, late_busy;
    exp_r = model(W'(70), W'(80), W'(97), 1'b0);
    a = W'(70); b = W'(80); p = W'(97); op = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; vc = -1; nv = 0; late_busy = 0;
    for (int c = 1; c <= 10; c++) begin
      if (c == 2) begin
        a = W'(3); b = W'(4); start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (valid) begin
        nv++;
        if (vc < 0) vc = c;
        checks++;
        if (result !== exp_r) begin errors++; $display("FAIL run_start_result got=%0d exp=%0d", result, exp_r); end
      end
      if (c > NL + 1 && busy) late_busy++;
      if (c < 10) tick();
    end
    checks++; if (vc !== NL + 1) begin errors++; $display("FAIL run_start_latency got=%0d exp=%0d", vc, NL + 1); end
    checks++; if (nv !== 1 || late_busy !== 0) begin
      errors++; $display("FAIL run_start_queued pulses=%0d late_busy=%0d exp=1,0", nv, late_busy);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [W-1:0] r, exp_r;
    int vc, bf, nb, nv, seen;
    a = W'(33); b = W'(44); p = W'(97); op = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_pre_busy got=%b exp=1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || valid !== 1'b0 || result !== '0) begin
      errors++; $display("FAIL mid_reset busy=%b valid=%b result=%h exp=0,0,0", busy, valid, result);
    end
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (valid || busy) seen++;
      tick();
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL mid_no_pulse got=%0d exp=0", seen); end
    exp_r = model(W'(60), W'(50), W'(97), 1'b0);
    do_op(W'(60), W'(50), W'(97), 1'b0, r, vc, bf, nb, nv);
    checks++; if (r !== exp_r || vc !== NL + 1) begin
      errors++; $display("FAIL mid_recover got=%0d exp=%0d vcyc=%0d", r, exp_r, vc);
    end
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_p256();
    test_sub();
    test_random();
    test_back_to_back();
    test_start_in_run();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
